// File: rtl/modular_square_ggg_unload_normalizer.sv
// Snapshots the squarer's redundant coefficients and streams them out as
// canonical WORD_LEN-bit digits, LSW first, with serial carry propagation.
module modular_square_ggg_unload_normalizer #(
  parameter  int WORD_LEN     = 50,
  parameter  int SQ_REG_LEN   = 51,
  parameter  int NUM_ELEMENTS = 21,
  localparam int IDX_W        = $clog2(NUM_ELEMENTS),
  localparam int CARRY_W      = SQ_REG_LEN - WORD_LEN + 1
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [NUM_ELEMENTS*SQ_REG_LEN-1:0] sq_in,
  output logic                               busy,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [WORD_LEN-1:0]                out_data,
  output logic [IDX_W-1:0]                   out_index,
  output logic                               out_last,
  output logic                               done,
  output logic [CARRY_W-1:0]                 final_carry,
  output logic                               overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEMENTS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                             state;
  logic [NUM_ELEMENTS*SQ_REG_LEN-1:0] snap;
  logic [CARRY_W-1:0]                 carry;
  logic [IDX_W-1:0]                   idx;
  logic [SQ_REG_LEN:0]                sum;
  logic [CARRY_W-1:0]                 next_carry;
  logic                               fire;
  logic                               at_last;

  // The snapshot shifts down on each handshake, so the current element is
  // always at the bottom and no wide read mux is needed.
  assign sum        = {1'b0, snap[SQ_REG_LEN-1:0]} + {{WORD_LEN{1'b0}}, carry};
  assign next_carry = sum[SQ_REG_LEN:WORD_LEN];
  assign at_last    = (idx == LAST_IDX);
  assign fire       = (state == STREAM) && out_ready;

  assign busy      = (state == STREAM);
  assign out_valid = (state == STREAM);
  assign out_data  = sum[WORD_LEN-1:0];
  assign out_index = idx;
  assign out_last  = (state == STREAM) && at_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      carry       <= '0;
      idx         <= '0;
      done        <= 1'b0;
      final_carry <= '0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            snap  <= sq_in;
            carry <= '0;
            idx   <= '0;
            state <= STREAM;
          end
        end
        STREAM: begin
          if (fire) begin
            if (at_last) begin
              final_carry <= next_carry;
              overflow    <= (next_carry != '0);
              done        <= 1'b1;
              state       <= IDLE;
            end else begin
              carry <= next_carry;
              idx   <= idx + IDX_W'(1);
              snap  <= snap >> SQ_REG_LEN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_modular_square_ggg_unload_normalizer.sv
// Directed, table-driven bench for the coefficient unload normalizer (4 elements).
module tb_modular_square_ggg_unload_normalizer;

  localparam int WL = 50;
  localparam int SL = 51;
  localparam int NE = 4;
  localparam int IW = 2;
  localparam int CW = 2;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               start = 1'b0;
  logic [NE*SL-1:0]   sq_in = '0;
  logic               busy, out_valid, out_last, done, overflow;
  logic               out_ready = 1'b0;
  logic [WL-1:0]      out_data;
  logic [IW-1:0]      out_index;
  logic [CW-1:0]      final_carry;

  int total = 0;
  int bad   = 0;

  modular_square_ggg_unload_normalizer #(
    .WORD_LEN(WL), .SQ_REG_LEN(SL), .NUM_ELEMENTS(NE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .sq_in(sq_in),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .done(done), .final_carry(final_carry), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [SL-1:0] c [NE];
    logic [WL-1:0] w [NE];
    logic [CW-1:0] fc;
    logic          ovf;
  } vec_t;

  vec_t vecs [4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic launch(input vec_t v);
    for (int i = 0; i < NE; i++) sq_in[i*SL +: SL] = v.c[i];
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered one cycle after the accepting start edge; returns at the done cycle.
  task automatic body(input vec_t v, input logic [6:0] pat, input int restart_at);
    int k = 0;
    int cyc = 0;
    int p = 0;
    bit stalled = 0;
    bit rs = 0;
    logic [WL-1:0] hd;
    logic [IW-1:0] hi;
    while (k < NE && cyc < 40) begin
      out_ready = pat[p % 7];
      p++;
      start = 1'b0;
      if (restart_at == k && !rs) begin
        start = 1'b1;
        sq_in = '0;
        rs = 1;
      end
      chk("out_valid", 64'(out_valid), 64'd1);
      chk("busy", 64'(busy), 64'd1);
      chk("done_early", 64'(done), 64'd0);
      if (stalled) begin
        chk("hold_data", 64'(out_data), 64'(hd));
        chk("hold_index", 64'(out_index), 64'(hi));
      end
      if (out_ready) begin
        chk("word", 64'(out_data), 64'(v.w[k]));
        chk("index", 64'(out_index), 64'(k));
        chk("last", 64'(out_last), 64'(k == NE - 1));
        k++;
        stalled = 0;
      end else begin
        stalled = 1;
        hd = out_data;
        hi = out_index;
      end
      tick();
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b0;
    if (k < NE) chk("stream_timeout", 64'(k), 64'(NE));
    if (pat == 7'h7f) chk("stream_cycles", 64'(cyc), 64'(NE));
    chk("done", 64'(done), 64'd1);
    chk("busy_after", 64'(busy), 64'd0);
    chk("valid_after", 64'(out_valid), 64'd0);
    chk("final_carry", 64'(final_carry), 64'(v.fc));
    chk("overflow", 64'(overflow), 64'(v.ovf));
  endtask

  initial begin
    // all 2^51-1: carries ripple up to a final carry of 2
    vecs[0].c = '{51'h7FFFFFFFFFFFF, 51'h7FFFFFFFFFFFF, 51'h7FFFFFFFFFFFF, 51'h7FFFFFFFFFFFF};
    vecs[0].w = '{50'h3FFFFFFFFFFFF, 50'h0, 50'h1, 50'h1};
    vecs[0].fc = 2'd2; vecs[0].ovf = 1'b1;
    vecs[1].c = '{51'd5, 51'd7, 51'd9, 51'd11};
    vecs[1].w = '{50'd5, 50'd7, 50'd9, 50'd11};
    vecs[1].fc = 2'd0; vecs[1].ovf = 1'b0;
    vecs[2].c = '{51'h4000000000000, 51'd0, 51'd0, 51'd0};
    vecs[2].w = '{50'd0, 50'd1, 50'd0, 50'd0};
    vecs[2].fc = 2'd0; vecs[2].ovf = 1'b0;
    vecs[3].c = '{51'h3FFFFFFFFFFFF, 51'd1, 51'h7FFFFFFFFFFFF, 51'd0};
    vecs[3].w = '{50'h3FFFFFFFFFFFF, 50'd1, 50'h3FFFFFFFFFFFF, 50'd1};
    vecs[3].fc = 2'd0; vecs[3].ovf = 1'b0;

    repeat (3) tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_index", 64'(out_index), 64'd0);
    chk("rst_fc", 64'(final_carry), 64'd0);

    for (int i = 0; i < 4; i++) begin
      launch(vecs[i]);
      body(vecs[i], 7'h7f, -1);
      tick();
      chk("done_pulse_end", 64'(done), 64'd0);
    end

    // backpressure pattern 1,0,0,1,0,1,1
    launch(vecs[0]);
    body(vecs[0], 7'b1101001, -1);
    tick();

    // start while streaming with zeroed sq_in must be ignored
    launch(vecs[0]);
    body(vecs[0], 7'h7f, 1);
    tick();

    // reset mid-stream at the second word
    launch(vecs[0]);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("pre_reset_index", 64'(out_index), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_done", 64'(done), 64'd0);
    chk("mid_rst_fc", 64'(final_carry), 64'd0);
    tick();
    chk("mid_rst_done2", 64'(done), 64'd0);
    launch(vecs[2]);
    body(vecs[2], 7'h7f, -1);
    tick();

    // back-to-back: start in the done cycle
    launch(vecs[0]);
    body(vecs[0], 7'h7f, -1);
    for (int i = 0; i < NE; i++) sq_in[i*SL +: SL] = vecs[1].c[i];
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("b2b_fc_held", 64'(final_carry), 64'd2);
    chk("b2b_ovf_held", 64'(overflow), 64'd1);
    body(vecs[1], 7'h7f, -1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
